// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, registers imem read data toward decode with a
// valid/ready handshake, and takes redirects with a one-cycle flush. FETCH_PERF_EN adds counters.
module instr_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 5,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StFlush} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] opc_q;
    logic              load;
    logic              accept;
    logic              slot_free;

    assign accept    = valid_q & out_ready;
    assign slot_free = ~valid_q | out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        load    = 1'b0;

        if (redirect_valid) begin
            // Redirect beats everything, including a same-cycle accept.
            pc_d    = redirect_target;
            valid_d = 1'b0;
            state_d = run ? StFlush : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) valid_d = 1'b0;
                    if (run) state_d = StFetch;
                end
                StFetch, StHold: begin
                    if (!run) begin
                        // Drain: keep the pending word until decode takes it.
                        if (accept) valid_d = 1'b0;
                        if (!valid_q || accept) state_d = StIdle;
                    end else if (slot_free) begin
                        load    = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StHold;
                    end
                end
                StFlush: begin
                    valid_d = 1'b0;
                    state_d = run ? StFetch : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            opc_q   <= '0;
        end else if (load) begin
            instr_q <= imem_data;
            opc_q   <= pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == StFlush) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign busy      = (state_q != StIdle);

endmodule
